// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: widths, FSM encoding, S-box layers,
// bit permutation and key-schedule steps used by the encryptor and decryptor.
package present_pkg;

  localparam int BLOCK_W    = 64;
  localparam int KEY_W      = 80;
  localparam int NUM_ROUNDS = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KEXP  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  4'hF: y = 4'hA;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  // The forward permutation sends bit i to (16*i) mod 63, so the inverse gathers from there.
  function automatic logic [BLOCK_W-1:0] p_inv(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    for (int j = 0; j < 63; j++) begin
      y[6'(j)] = x[6'((16 * j) % 63)];
    end
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [BLOCK_W-1:0] sinv_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    for (int n = 0; n < 16; n++) begin
      y[6'(4 * n) +: 4] = sbox_inv(x[6'(4 * n) +: 4]);
    end
    return y;
  endfunction

  function automatic logic [KEY_W-1:0] fwd_step(input logic [KEY_W-1:0] k,
                                                input logic [4:0]       rc);
    logic [KEY_W-1:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = sbox(t[79:76]);
    t[19:15]   = t[19:15] ^ rc;
    return t;
  endfunction

  function automatic logic [KEY_W-1:0] inv_step(input logic [KEY_W-1:0] k,
                                                input logic [4:0]       rc);
    logic [KEY_W-1:0] t;
    t          = k;
    t[19:15]   = t[19:15] ^ rc;
    t[79:76]   = sbox_inv(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

endpackage

// File: rtl/present_key_step.sv
// Single key-schedule update stage; steps forward while expanding to K32
// and backward while unwinding the rounds.
module present_key_step
  import present_pkg::*;
(
  input  logic             inverse,
  input  logic [4:0]       round_cnt,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_out
);

  // Select forward or inverse schedule step for the current counter value.
  always_comb begin
    key_out = key_in;
    if (inverse) begin
      key_out = inv_step(key_in, round_cnt);
    end else begin
      key_out = fwd_step(key_in, round_cnt);
    end
  end

endmodule

// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryptor: expands the user key to K32 in 31 cycles,
// then peels off one round per cycle and presents plaintext on a handshake.
module present_decrypt
  import present_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] ciphertext,
  input  logic [KEY_W-1:0]   orig_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] plaintext
);

  fsm_state_t         fsm_r;
  fsm_state_t         fsm_next_s;
  logic [BLOCK_W-1:0] ct_r;
  logic [BLOCK_W-1:0] state_r;
  logic [KEY_W-1:0]   key_r;
  logic [KEY_W-1:0]   key_next_s;
  logic [4:0]         cnt_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               inverse_s;

  assign inverse_s = (fsm_r == ST_ROUND);
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign plaintext = state_r;

  present_key_step u_key_step (
    .inverse   (inverse_s),
    .round_cnt (cnt_r),
    .key_in    (key_r),
    .key_out   (key_next_s)
  );

  // Next-state logic for the job sequencer.
  always_comb begin
    fsm_next_s = fsm_r;
    case (fsm_r)
      ST_IDLE: begin
        if (in_valid) fsm_next_s = ST_KEXP;
        else          fsm_next_s = ST_IDLE;
      end
      ST_KEXP: begin
        if (cnt_r == 5'(NUM_ROUNDS)) fsm_next_s = ST_ROUND;
        else                         fsm_next_s = ST_KEXP;
      end
      ST_ROUND: begin
        if (cnt_r == 5'd1) fsm_next_s = ST_DONE;
        else               fsm_next_s = ST_ROUND;
      end
      ST_DONE: begin
        if (out_ready) fsm_next_s = ST_IDLE;
        else           fsm_next_s = ST_DONE;
      end
      default: fsm_next_s = ST_IDLE;
    endcase
  end

  // Sequencer state and registered handshake flags derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r       <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      fsm_r       <= fsm_next_s;
      in_ready_r  <= (fsm_next_s == ST_IDLE);
      out_valid_r <= (fsm_next_s == ST_DONE);
    end
  end

  // Datapath: capture, key expansion, and inverse rounds. DONE holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ct_r    <= '0;
      state_r <= '0;
      key_r   <= '0;
      cnt_r   <= 5'd0;
    end else begin
      case (fsm_r)
        ST_IDLE: begin
          if (in_valid) begin
            ct_r  <= ciphertext;
            key_r <= orig_key;
            cnt_r <= 5'd1;
          end
        end
        ST_KEXP: begin
          key_r <= key_next_s;
          if (cnt_r == 5'(NUM_ROUNDS)) begin
            // key_next_s is K32 here: strip the final whitening key.
            state_r <= ct_r ^ key_next_s[KEY_W-1 -: BLOCK_W];
            cnt_r   <= 5'(NUM_ROUNDS);
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end
        ST_ROUND: begin
          state_r <= sinv_layer(p_inv(state_r)) ^ key_next_s[KEY_W-1 -: BLOCK_W];
          key_r   <= key_next_s;
          cnt_r   <= cnt_r - 5'd1;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule
